// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: buffers ALU/LSU writebacks in an in-order FIFO and drains one per cycle to the register file.
module rf_writeback_arbiter #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [AW-1:0]             lsu_rd,
  input  logic [XLEN-1:0]           lsu_data,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [AW-1:0]             alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  output logic                      rf_we,
  output logic [AW-1:0]             rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  input  logic [AW-1:0]             chk_rd,
  output logic                      chk_hit,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  logic [AW-1:0]   rd_q  [DEPTH];
  logic [AW-1:0]   rd_d  [DEPTH];
  logic [XLEN-1:0] dat_q [DEPTH];
  logic [XLEN-1:0] dat_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]   occ_q, occ_d, free;
  logic            lsu_take, lsu_en, alu_en;
  // Free space ignores the same-cycle drain so ready never depends on the pop.
  always_comb begin
    free      = OW'(DEPTH) - occ_q;
    lsu_take  = lsu_valid && lsu_rd != '0;
    lsu_ready = free != '0;
    alu_ready = free >= OW'(2) || (free == OW'(1) && !lsu_take);
    lsu_en    = lsu_take && lsu_ready;
    alu_en    = alu_valid && alu_ready && alu_rd != '0;
    rf_we     = occ_q != '0;
    rf_waddr  = rf_we ? rd_q[head_q] : '0;
    rf_wdata  = rf_we ? dat_q[head_q] : '0;
    occupancy = occ_q;
    rd_d      = rd_q;
    dat_d     = dat_q;
    if (lsu_en) begin
      rd_d[tail_q]  = lsu_rd;
      dat_d[tail_q] = lsu_data;
    end
    // LSU lands first so a same-rd ALU write ends up last in the register.
    if (alu_en) begin
      rd_d[tail_q + PW'(lsu_en)]  = alu_rd;
      dat_d[tail_q + PW'(lsu_en)] = alu_data;
    end
    tail_d  = tail_q + PW'(lsu_en) + PW'(alu_en);
    head_d  = head_q + PW'(rf_we);
    occ_d   = occ_q + OW'(lsu_en) + OW'(alu_en) - OW'(rf_we);
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (chk_rd != '0 && OW'(i) < occ_q && rd_q[head_q + PW'(i)] == chk_rd) chk_hit = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      rd_q   <= '{default: '0};
      dat_q  <= '{default: '0};
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rd_q   <= rd_d;
      dat_q  <= dat_d;
    end
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: scoreboard bench; expected writes queued at acceptance, popped on rf_we.
module tb_rf_writeback_arbiter;
  localparam int XLEN = 64, AW = 5, DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic lsu_valid, lsu_ready, alu_valid, alu_ready, rf_we, chk_hit;
  logic [AW-1:0] lsu_rd, alu_rd, rf_waddr, chk_rd;
  logic [XLEN-1:0] lsu_data, alu_data, rf_wdata;
  logic [$clog2(DEPTH):0] occupancy;
  int checks = 0, errors = 0, max_occ = 0, alu_stalls = 0;
  bit lsu_acc, alu_acc;
  logic [AW+XLEN-1:0] q[$];

  rf_writeback_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_rd(chk_rd), .chk_hit(chk_hit), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit lv, input logic [AW-1:0] lr, input logic [XLEN-1:0] ld,
                       input bit av, input logic [AW-1:0] ar, input logic [XLEN-1:0] ad);
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    alu_valid = av; alu_rd = ar; alu_data = ad;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle model: compare outputs against queue head, then predict acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      int fr;
      bit hit, lt, lr, ar;
      hit = 1'b0;
      foreach (q[i]) if (chk_rd != 0 && q[i][AW+XLEN-1:XLEN] == chk_rd) hit = 1'b1;
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("rf_we", 64'(rf_we), 64'(q.size() != 0));
      check("rf_waddr", 64'(rf_waddr), q.size() != 0 ? 64'(q[0][AW+XLEN-1:XLEN]) : 64'd0);
      check("rf_wdata", rf_wdata, q.size() != 0 ? q[0][XLEN-1:0] : 64'd0);
      check("chk_hit", 64'(chk_hit), 64'(hit));
      if (q.size() > max_occ) max_occ = q.size();
      fr = DEPTH - q.size();
      lt = lsu_valid && lsu_rd != 0;
      lr = fr >= 1;
      ar = fr >= 2 || (fr == 1 && !lt);
      check("lsu_ready", 64'(lsu_ready), 64'(lr));
      check("alu_ready", 64'(alu_ready), 64'(ar));
      if (alu_valid && !ar) alu_stalls++;
      if (q.size() != 0) void'(q.pop_front());
      lsu_acc = lsu_valid && lr;
      alu_acc = alu_valid && ar;
      if (lsu_acc && lsu_rd != 0) q.push_back({lsu_rd, lsu_data});
      if (alu_acc && alu_rd != 0) q.push_back({alu_rd, alu_data});
    end
  end

  initial begin
    logic [AW-1:0] lr, ar;
    drive(0, 0, 0, 0, 0, 0);
    chk_rd = 0;
    #1;
    check("rst_we", 64'(rf_we), 0);
    check("rst_occ", 64'(occupancy), 0);
    check("rst_waddr", 64'(rf_waddr), 0);
    check("rst_wdata", rf_wdata, 0);
    #10 rst_n = 1'b1;
    step();
    // single ALU write, one-cycle latency
    drive(0, 0, 0, 1, 5, 64'hAA);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    // same-rd collision: LSU then ALU
    drive(1, 3, 64'd1, 1, 3, 64'd2);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step();
    // x0 write dropped
    drive(0, 0, 0, 1, 0, 64'hFF);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    // pending-write lookup
    chk_rd = 7;
    drive(0, 0, 0, 1, 7, 64'h77);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk_rd = 0;
    drive(1, 7, 64'h78, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    // both ports streaming with held requests until accepted
    lr = 1; ar = 16;
    drive(1, lr, 64'($urandom), 1, ar, 64'($urandom));
    repeat (30) begin
      step();
      if (lsu_acc) begin lr = lr == 15 ? 5'd1 : lr + 5'd1; lsu_rd = lr; lsu_data = {$urandom, $urandom}; end
      if (alu_acc) begin ar = ar == 31 ? 5'd16 : ar + 5'd1; alu_rd = ar; alu_data = {$urandom, $urandom}; end
      chk_rd = lr;
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();
    // with the pop never credited, steady two-port traffic tops out one below DEPTH
    check("t4_max_occ", 64'(max_occ), 64'(DEPTH - 1));
    check("t4_alu_stalled", 64'(alu_stalls != 0), 1);
    check("t4_drained", 64'(q.size()), 0);
    // async reset with three entries queued
    chk_rd = 12;
    drive(1, 10, 64'h10, 1, 11, 64'h11);
    step();
    drive(1, 12, 64'h12, 1, 13, 64'h13);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("t6_occ_before", 64'(occupancy), 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_we", 64'(rf_we), 0);
    check("t6_rst_occ", 64'(occupancy), 0);
    check("t6_rst_hit", 64'(chk_hit), 0);
    q.delete();
    step();
    rst_n = 1'b1;
    step();
    drive(0, 0, 0, 1, 9, 64'h99);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step();
    check("t6_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
